// File: rtl/loop_buffer_ctrl_pkg.sv
// Shared definitions for the loop buffer: control-flow opcodes, FSM state encoding
// and opcode classification helpers.
package loop_pkg;

   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BTYPE = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [1:0] TRACK   = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] REUSE   = 2'd2;
   localparam logic [1:0] FLUSH   = 2'd3;

   // Only PC-relative transfers can close a loop whose target is known at capture time.
   function automatic logic opens_loop(input logic [6:0] op);
      return (op == OP_JAL) || (op == OP_BTYPE);
   endfunction

   function automatic logic is_ctrl_op(input logic [6:0] op);
      return (op == OP_JAL) || (op == OP_BTYPE) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/loop_buffer_mem.sv
// Loop body storage: one write port, one read port, registered read data.
module loop_buffer_mem
   import loop_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 32,
   localparam int IDX_W    = $clog2(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [XLEN-1:0]  wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [XLEN-1:0]  rd_data
);

   logic [XLEN-1:0] mem [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/loop_buffer_ctrl.sv
// Loop-stream detector: captures a short backward-branch loop body from IF/ID and
// replays it from a local buffer while fetch is stalled, until the loop exits.
module loop_buffer_ctrl
   import loop_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 32,
   localparam int IDX_W    = $clog2(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  instruction,
   input  logic [XLEN-1:0]  curr_PC,
   input  logic [XLEN-1:0]  immediate,
   input  logic             mispredict,
   output logic             block_signal,
   output logic             reuse_signal,
   output logic             replay_valid,
   output logic [XLEN-1:0]  replay_instr,
   output logic [XLEN-1:0]  replay_pc,
   output logic             flush,
   output logic [XLEN-1:0]  new_pc,
   output logic [IDX_W:0]   loop_len
);

   localparam logic signed [XLEN-1:0] MIN_OFF = -$signed(XLEN'(4 * BUF_DEPTH));
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BUF_DEPTH - 1);
   localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W:0]         LEN_ONE  = (IDX_W + 1)'(1);

   logic [1:0]       state;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] rd_next;
   logic [IDX_W-1:0] rd_addr;
   logic [XLEN-1:0]  br_pc;
   logic [XLEN-1:0]  tgt_pc;
   logic [XLEN-1:0]  exp_pc;
   logic [XLEN-1:0]  rd_data;
   logic [6:0]       opcode;
   logic             candidate;
   logic             pc_ok;
   logic             at_br;
   logic             body_ok;
   logic             wr_en;

   assign opcode    = instruction[6:0];
   assign candidate = if_valid && opens_loop(opcode) && immediate[XLEN-1]
                      && ($signed(immediate) >= MIN_OFF);

   // Captured body must be straight-line code ending in the branch that opened it.
   assign exp_pc  = tgt_pc + XLEN'({wr_idx, 2'b00});
   assign pc_ok   = (curr_PC == exp_pc);
   assign at_br   = (curr_PC == br_pc);
   assign body_ok = pc_ok && !(is_ctrl_op(opcode) && !at_br);
   assign wr_en   = (state == CAPTURE) && if_valid && !mispredict && body_ok;

   // Read is one cycle late, so the RAM is addressed with the entry after the one shown.
   assign rd_next = (({1'b0, rd_idx} + LEN_ONE) == loop_len) ? '0 : rd_idx + IDX_ONE;
   assign rd_addr = (state == REUSE) ? rd_next : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= TRACK;
         wr_idx   <= '0;
         rd_idx   <= '0;
         loop_len <= '0;
      end else begin
         case (state)
            TRACK: begin
               if (candidate) begin
                  state  <= CAPTURE;
                  wr_idx <= '0;
               end
            end
            CAPTURE: begin
               if (mispredict) begin
                  state <= TRACK;
               end else if (if_valid) begin
                  if (!body_ok) begin
                     state <= TRACK;
                  end else if (at_br) begin
                     loop_len <= {1'b0, wr_idx} + LEN_ONE;
                     rd_idx   <= '0;
                     state    <= REUSE;
                  end else if (wr_idx == LAST_IDX) begin
                     state <= TRACK;
                  end else begin
                     wr_idx <= wr_idx + IDX_ONE;
                  end
               end
            end
            REUSE: begin
               if (mispredict) begin
                  state <= FLUSH;
               end else begin
                  rd_idx <= rd_next;
               end
            end
            default: begin
               loop_len <= '0;
               state    <= TRACK;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == TRACK) && candidate) begin
         br_pc  <= curr_PC;
         tgt_pc <= curr_PC + immediate;
      end
   end

   loop_buffer_mem #(
      .XLEN      (XLEN),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (instruction),
      .rd_idx  (rd_addr),
      .rd_data (rd_data)
   );

   assign reuse_signal = (state == REUSE);
   assign block_signal = reuse_signal;
   assign replay_valid = reuse_signal;
   assign replay_instr = reuse_signal ? rd_data : '0;
   assign replay_pc    = reuse_signal ? (tgt_pc + XLEN'({rd_idx, 2'b00})) : '0;
   assign flush        = (state == FLUSH);
   assign new_pc       = flush ? (br_pc + XLEN'(4)) : '0;

endmodule
